// File: rtl/seq_tx_pkg.sv
// Shared types and constants for the serial pattern transmitter.
// Holds the FSM state encoding, the default pattern and index-width helpers.
package seq_tx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StGap,
    StDone
  } state_e;

  localparam int unsigned PatWDefault = 4;
  localparam logic [PatWDefault-1:0] DefPat = 4'b1010;
  localparam int unsigned IdxW = $clog2(PatWDefault);

  // Bit-index width for an arbitrary pattern width; never narrower than 1.
  function automatic int unsigned idx_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/piso_shift.sv
// Parallel-load, MSB-first shift register with load/shift enables.
// Exposes the current MSB and the bit that will become MSB on the next shift.
module piso_shift #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb,
  output logic             msb_next
);

  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (load) begin
      shreg_d = din;
    end else if (shift) begin
      shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign msb      = shreg_q[WIDTH-1];
  assign msb_next = shreg_q[WIDTH-2];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: emits a latched pattern MSB-first, repeated a
// programmed number of times with an optional idle gap between repetitions.
module seq_pattern_tx
  import seq_tx_pkg::*;
#(
  parameter int unsigned         PAT_W   = 4,
  parameter logic [PAT_W-1:0]    DEF_PAT = PAT_W'(DefPat),
  parameter int unsigned         CNT_W   = 8,
  parameter int unsigned         GAP_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             use_def,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] reps,
  input  logic [GAP_W-1:0] gap,
  input  logic             abort,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             last_bit,
  output logic             busy,
  output logic             done
);

  localparam int unsigned IdxBits = idx_width(PAT_W);
  localparam logic [IdxBits-1:0] IdxMax = IdxBits'(PAT_W - 1);

  state_e             state_q, state_d;
  logic [IdxBits-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]   reps_q, reps_d;
  logic [GAP_W-1:0]   gap_len_q, gap_len_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [PAT_W-1:0]   pat_q, pat_d;

  logic             sh_load;
  logic             sh_shift;
  logic [PAT_W-1:0] sh_din;
  logic             sh_msb;
  logic             sh_msb_next;
  logic             msb_d;

  piso_shift #(
    .WIDTH (PAT_W)
  ) u_piso (
    .clk      (clk),
    .rst      (rst),
    .load     (sh_load),
    .shift    (sh_shift),
    .din      (sh_din),
    .msb      (sh_msb),
    .msb_next (sh_msb_next)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    reps_d    = reps_q;
    gap_len_d = gap_len_q;
    gap_cnt_d = gap_cnt_q;
    pat_d     = pat_q;
    sh_load   = 1'b0;
    sh_shift  = 1'b0;
    sh_din    = pat_q;

    if (abort && (state_q != StIdle)) begin
      state_d   = StIdle;
      idx_d     = '0;
      reps_d    = '0;
      gap_cnt_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // abort in the same cycle drops the request
          if (start && !abort && (reps != '0)) begin
            pat_d     = use_def ? DEF_PAT : pattern;
            reps_d    = reps;
            gap_len_d = gap;
            idx_d     = IdxMax;
            sh_load   = 1'b1;
            sh_din    = pat_d;
            state_d   = StSend;
          end
        end
        StSend: begin
          if (idx_q == '0) begin
            if (reps_q == CNT_W'(1)) begin
              reps_d  = '0;
              state_d = StDone;
            end else begin
              reps_d = reps_q - CNT_W'(1);
              if (gap_len_q == '0) begin
                sh_load = 1'b1;
                idx_d   = IdxMax;
              end else begin
                gap_cnt_d = gap_len_q;
                state_d   = StGap;
              end
            end
          end else begin
            sh_shift = 1'b1;
            idx_d    = idx_q - IdxBits'(1);
          end
        end
        StGap: begin
          if (gap_cnt_q == GAP_W'(1)) begin
            gap_cnt_d = '0;
            sh_load   = 1'b1;
            idx_d     = IdxMax;
            state_d   = StSend;
          end else begin
            gap_cnt_d = gap_cnt_q - GAP_W'(1);
          end
        end
        StDone: begin
          idx_d   = '0;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Value the shift register's MSB will hold after this edge.
  always_comb begin
    msb_d = sh_msb;
    if (sh_load) begin
      msb_d = sh_din[PAT_W-1];
    end else if (sh_shift) begin
      msb_d = sh_msb_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      reps_q    <= '0;
      gap_len_q <= '0;
      gap_cnt_q <= '0;
      pat_q     <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      last_bit  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      reps_q    <= reps_d;
      gap_len_q <= gap_len_d;
      gap_cnt_q <= gap_cnt_d;
      pat_q     <= pat_d;
      ser_out   <= (state_d == StSend) && msb_d;
      ser_valid <= (state_d == StSend);
      last_bit  <= (state_d == StSend) && (idx_d == '0);
      busy      <= (state_d != StIdle);
      done      <= (state_d == StDone);
    end
  end

endmodule
